// File: rtl/proc_control.sv
// Multi-cycle control unit for the 16-bit processor datapath: sequences each
// instruction over IDLE/T1/T2/T3 and decodes register enables, bus select and ALU mode.
module proc_control #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         run,
    input  logic [n-1:0] ir,
    input  logic         g_nz,
    output logic         ir_we,
    output logic [7:0]   r_we,
    output logic         a_we,
    output logic         g_we,
    output logic         addr_we,
    output logic         dout_we,
    output logic         mem_we,
    output logic [3:0]   bus_sel,
    output logic         add_sub,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_LD   = 3'b100,
        OP_ST   = 3'b101,
        OP_MVNZ = 3'b110,
        OP_NOP  = 3'b111
    } opcode_t;

    localparam logic [3:0] SEL_G   = 4'd8;
    localparam logic [3:0] SEL_DIN = 4'd9;

    state_t     state, state_next;
    opcode_t    opcode;
    logic [2:0] x, y;
    logic       unused_ir_bits;

    assign opcode         = opcode_t'(ir[15:13]);
    assign x              = ir[12:10];
    assign y              = ir[9:7];
    assign unused_ir_bits = ^ir[6:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        ir_we      = 1'b0;
        r_we       = '0;
        a_we       = 1'b0;
        g_we       = 1'b0;
        addr_we    = 1'b0;
        dout_we    = 1'b0;
        mem_we     = 1'b0;
        bus_sel    = '0;
        add_sub    = 1'b0;
        done       = 1'b0;

        unique case (state)
            IDLE: begin
                ir_we      = run;
                state_next = run ? T1 : IDLE;
            end
            T1: begin
                unique case (opcode)
                    OP_MV: begin
                        bus_sel = {1'b0, y};
                        r_we[x] = 1'b1;
                        done    = 1'b1;
                    end
                    OP_MVI: begin
                        bus_sel = SEL_DIN;
                        r_we[x] = 1'b1;
                        done    = 1'b1;
                    end
                    OP_MVNZ: begin
                        done = 1'b1;
                        if (g_nz) begin
                            bus_sel = {1'b0, y};
                            r_we[x] = 1'b1;
                        end
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel    = {1'b0, x};
                        a_we       = 1'b1;
                        state_next = T2;
                    end
                    OP_LD, OP_ST: begin
                        bus_sel    = {1'b0, y};
                        addr_we    = 1'b1;
                        state_next = T2;
                    end
                    default: begin
                        done = 1'b1;
                    end
                endcase
            end
            T2: begin
                // opcodes with no T2 step fall through to IDLE with every output low
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        bus_sel    = {1'b0, y};
                        g_we       = 1'b1;
                        add_sub    = (opcode == OP_SUB);
                        state_next = T3;
                    end
                    OP_LD: begin
                        state_next = T3;
                    end
                    OP_ST: begin
                        bus_sel    = {1'b0, x};
                        dout_we    = 1'b1;
                        state_next = T3;
                    end
                    default: ;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        bus_sel = SEL_G;
                        r_we[x] = 1'b1;
                        done    = 1'b1;
                    end
                    OP_LD: begin
                        bus_sel = SEL_DIN;
                        r_we[x] = 1'b1;
                        done    = 1'b1;
                    end
                    OP_ST: begin
                        mem_we = 1'b1;
                        done   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        // reset masks the combinational decode so ir_we stays low even with run high
        if (!resetn) begin
            ir_we   = 1'b0;
            r_we    = '0;
            a_we    = 1'b0;
            g_we    = 1'b0;
            addr_we = 1'b0;
            dout_we = 1'b0;
            mem_we  = 1'b0;
            bus_sel = '0;
            add_sub = 1'b0;
            done    = 1'b0;
        end
    end

endmodule

// File: tb/tb_proc_control.sv
// Self-checking bench for proc_control: per-instruction expected output tables
// built from the opcode rules, with directed and randomized instruction streams.
module tb_proc_control;

    logic        clk;
    logic        resetn;
    logic        run;
    logic [15:0] ir;
    logic        g_nz;
    logic        ir_we;
    logic [7:0]  r_we;
    logic        a_we, g_we, addr_we, dout_we, mem_we;
    logic [3:0]  bus_sel;
    logic        add_sub;
    logic        done;

    typedef struct packed {
        logic       ir_we;
        logic [7:0] r_we;
        logic       a_we;
        logic       g_we;
        logic       addr_we;
        logic       dout_we;
        logic       mem_we;
        logic [3:0] bus_sel;
        logic       add_sub;
        logic       done;
    } outs_t;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    outs_t       exp_q[$];

    proc_control #(.n(16)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .run     (run),
        .ir      (ir),
        .g_nz    (g_nz),
        .ir_we   (ir_we),
        .r_we    (r_we),
        .a_we    (a_we),
        .g_we    (g_we),
        .addr_we (addr_we),
        .dout_we (dout_we),
        .mem_we  (mem_we),
        .bus_sel (bus_sel),
        .add_sub (add_sub),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic outs_t observed();
        outs_t o;
        o = '{ir_we, r_we, a_we, g_we, addr_we, dout_we, mem_we, bus_sel, add_sub, done};
        return o;
    endfunction

    // Expected per-cycle outputs of one instruction, starting with the IDLE cycle that sees run.
    task automatic build_expected(input logic [15:0] instr, input logic gnz);
        logic [2:0] op, x, y;
        logic [7:0] oh;
        outs_t      s;
        op = instr[15:13];
        x  = instr[12:10];
        y  = instr[9:7];
        oh = 8'd1 << x;
        exp_q.delete();
        s = '0; s.ir_we = 1'b1; exp_q.push_back(s);
        case (op)
            3'd0: begin s = '0; s.bus_sel = {1'b0, y}; s.r_we = oh; s.done = 1'b1; exp_q.push_back(s); end
            3'd1: begin s = '0; s.bus_sel = 4'd9; s.r_we = oh; s.done = 1'b1; exp_q.push_back(s); end
            3'd6: begin
                s = '0; s.done = 1'b1;
                if (gnz) begin s.bus_sel = {1'b0, y}; s.r_we = oh; end
                exp_q.push_back(s);
            end
            3'd7: begin s = '0; s.done = 1'b1; exp_q.push_back(s); end
            3'd2, 3'd3: begin
                s = '0; s.bus_sel = {1'b0, x}; s.a_we = 1'b1; exp_q.push_back(s);
                s = '0; s.bus_sel = {1'b0, y}; s.g_we = 1'b1; s.add_sub = op[0]; exp_q.push_back(s);
                s = '0; s.bus_sel = 4'd8; s.r_we = oh; s.done = 1'b1; exp_q.push_back(s);
            end
            3'd4: begin
                s = '0; s.bus_sel = {1'b0, y}; s.addr_we = 1'b1; exp_q.push_back(s);
                s = '0; exp_q.push_back(s);
                s = '0; s.bus_sel = 4'd9; s.r_we = oh; s.done = 1'b1; exp_q.push_back(s);
            end
            default: begin
                s = '0; s.bus_sel = {1'b0, y}; s.addr_we = 1'b1; exp_q.push_back(s);
                s = '0; s.bus_sel = {1'b0, x}; s.dout_we = 1'b1; exp_q.push_back(s);
                s = '0; s.mem_we = 1'b1; s.done = 1'b1; exp_q.push_back(s);
            end
        endcase
    endtask

    task automatic run_instr(input logic [15:0] instr, input logic gnz, input bit hold_run,
                             input string tag);
        outs_t o;
        build_expected(instr, gnz);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            run  = (i == 0) ? 1'b1 : (hold_run ? 1'b1 : 1'($urandom_range(0, 1)));
            ir   = instr;
            g_nz = gnz;
            #1;
            o = observed();
            n_cmp++;
            if (o !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s ir=%h step=%0d: got %h required %h", tag, instr, i, o, exp_q[i]);
            end
        end
    endtask

    task automatic idle_cycles(input int unsigned cnt, input string tag);
        outs_t o;
        for (int unsigned i = 0; i < cnt; i++) begin
            @(negedge clk);
            run  = 1'b0;
            ir   = 16'($urandom);
            g_nz = 1'($urandom_range(0, 1));
            #1;
            o = observed();
            n_cmp++;
            if (o !== '0) begin
                n_err++;
                $display("FAIL %s idle=%0d: got %h required %h", tag, i, o, outs_t'(0));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        outs_t o;
        o = observed();
        n_cmp++;
        if (o !== '0) begin
            n_err++;
            $display("FAIL %s: got %h required %h", tag, o, outs_t'(0));
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; run = 1'b1; ir = 16'h2400; g_nz = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset_run_high");
        @(negedge clk);
        resetn = 1'b1; run = 1'b0;
        #1;
        check_zero("reset_release");
        idle_cycles(3, "post_reset_idle");
    endtask

    task automatic test_mvi();
        run_instr(16'h2400, 1'b0, 1'b0, "mvi_r1");
        idle_cycles(1, "mvi_after");
    endtask

    task automatic test_add_sub();
        run_instr(16'h4080, 1'b0, 1'b0, "add_r0_r1");
        idle_cycles(1, "add_after");
        run_instr(16'h6080, 1'b1, 1'b0, "sub_r0_r1");
        idle_cycles(1, "sub_after");
    endtask

    task automatic test_mvnz();
        run_instr(16'hC080, 1'b0, 1'b0, "mvnz_gz0");
        run_instr(16'hC080, 1'b1, 1'b0, "mvnz_gz1");
        idle_cycles(1, "mvnz_after");
    endtask

    task automatic test_back_to_back();
        run_instr(16'hA080, 1'b0, 1'b1, "st_b2b");
        run_instr(16'h8080, 1'b0, 1'b1, "ld_b2b");
        idle_cycles(2, "b2b_after");
    endtask

    task automatic test_reset_mid_add();
        outs_t o;
        build_expected(16'h4080, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            run = (i == 0); ir = 16'h4080; g_nz = 1'b0;
            #1;
            o = observed();
            n_cmp++;
            if (o !== exp_q[i]) begin
                n_err++;
                $display("FAIL mid_add_pre step=%0d: got %h required %h", i, o, exp_q[i]);
            end
        end
        #1 resetn = 1'b0;
        #1 check_zero("mid_add_reset_async");
        @(negedge clk);
        run = 1'b1;
        #1 check_zero("mid_add_reset_held");
        @(negedge clk);
        resetn = 1'b1; run = 1'b0;
        #1 check_zero("mid_add_release");
        idle_cycles(3, "mid_add_idle");
        run_instr(16'h0680, 1'b0, 1'b0, "mv_after_reset");
    endtask

    task automatic test_illegal();
        outs_t o;
        // add, then opcode swapped to mv while in T2
        build_expected(16'h4080, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            run = (i == 0); ir = 16'h4080;
            #1;
            o = observed();
            n_cmp++;
            if (o !== exp_q[i]) begin
                n_err++;
                $display("FAIL illegal_t2_pre step=%0d: got %h required %h", i, o, exp_q[i]);
            end
        end
        @(negedge clk);
        run = 1'b1; ir = 16'h0480;
        #1 check_zero("illegal_mv_in_t2");
        run_instr(16'h2C00, 1'b0, 1'b0, "mvi_after_illegal_t2");
        // ld, then opcode swapped to mvi while in T3
        build_expected(16'h8080, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            run = (i == 0); ir = 16'h8080;
            #1;
            o = observed();
            n_cmp++;
            if (o !== exp_q[i]) begin
                n_err++;
                $display("FAIL illegal_t3_pre step=%0d: got %h required %h", i, o, exp_q[i]);
            end
        end
        @(negedge clk);
        run = 1'b1; ir = 16'h2400;
        #1 check_zero("illegal_mvi_in_t3");
        run_instr(16'hE000, 1'b0, 1'b0, "nop_after_illegal_t3");
        idle_cycles(1, "illegal_after");
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            run_instr(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3), "random_gap");
        end
        idle_cycles(1, "random_end");
    endtask

    initial begin
        resetn = 1'b0; run = 1'b0; ir = '0; g_nz = 1'b0;
        test_reset();
        test_mvi();
        test_add_sub();
        test_mvnz();
        test_back_to_back();
        test_reset_mid_add();
        test_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/proc_control.md
# proc_control

Multi-cycle control unit for the 16-bit processor datapath. It sequences each instruction over up to four clock steps and drives the write-enable (`WE`) inputs of every datapath `regn` instance, the shared-bus select, and the ALU mode. It sits directly upstream of the register file, IR, A, G, ADDR and DOUT registers: its enables decide which register captures the bus on each rising clock edge.

## Interface
- `n`, 16: instruction width. The opcode and field positions below assume 16.
- `clk` input 1: rising-edge clock shared with all `regn` instances.
- `resetn` input 1: asynchronous, active-low reset.
- `run` input 1: start request, sampled only in IDLE.
- `ir` input n: output of the IR `regn`. Opcode `ir[15:13]`, X `ir[12:10]`, Y `ir[9:7]`, `ir[6:0]` ignored.
- `g_nz` input 1: G register is nonzero.
- `ir_we` output 1: IR write enable. IR loads from DIN.
- `r_we` output 8: one-hot write enables for R0..R7.
- `a_we`, `g_we`, `addr_we`, `dout_we` output 1 each: register write enables.
- `mem_we` output 1: memory write strobe.
- `bus_sel` output 4: shared-bus source. 0–7 selects R0–R7, 8 selects G, 9 selects DIN, 10–15 drive zero.
- `add_sub` output 1: ALU mode. 0 = add, 1 = subtract.
- `done` output 1: pulses for one cycle in the final step of each instruction.

## Operation
- Opcodes:
  - 000 mv
  - 001 mvi
  - 010 add
  - 011 sub
  - 100 ld
  - 101 st
  - 110 mvnz
  - 111 nop
- State is 2-bit: IDLE, T1, T2, T3. Only the state is registered. All outputs decode combinationally from state, `ir`, `run` and `g_nz`.
- Default for every output is 0. Listed signals are 1; `bus_sel` is as given.
- IDLE:
  - `ir_we = run`.
  - If `run`, go to T1. Otherwise stay in IDLE.
- T1:
  - mv: `bus_sel=Y`, `r_we[X]`, `done`. Go to IDLE.
  - mvi: `bus_sel=9`, `r_we[X]`, `done`. Go to IDLE. The immediate is on DIN during T1.
  - mvnz: `done`. If `g_nz`, also `bus_sel=Y`, `r_we[X]`. Go to IDLE.
  - add/sub: `bus_sel=X`, `a_we`. Go to T2.
  - ld/st: `bus_sel=Y`, `addr_we`. Go to T2.
  - nop: `done`. Go to IDLE.
- T2:
  - add/sub: `bus_sel=Y`, `g_we`, `add_sub = (opcode==011)`. Go to T3.
  - ld: no enables (memory read cycle). Go to T3.
  - st: `bus_sel=X`, `dout_we`. Go to T3.
- T3:
  - add/sub: `bus_sel=8`, `r_we[X]`, `done`. Go to IDLE.
  - ld: `bus_sel=9`, `r_we[X]`, `done`. Go to IDLE.
  - st: `mem_we`, `done`. Go to IDLE.
- Illegal state/opcode combinations (e.g. mv in T2) force IDLE on the next edge with all outputs 0.
- `r_we` is always zero or one-hot. It never has more than one bit set.
- `run` is ignored outside IDLE. A new instruction may start in the cycle right after `done`.

## Timing
- Reset (`resetn=0`):
  - State goes to IDLE immediately, without waiting for a clock edge.
  - All outputs are forced to 0 while reset is asserted, including `ir_we` even if `run=1`.
- Release: the first rising edge with `resetn=1` samples `run` in IDLE.
- Reset mid-instruction: the instruction is abandoned. No further enables are issued and `done` is not raised.
- Cycles from the `run` edge to `done`, inclusive of the IDLE cycle:
  - mv/mvi/mvnz/nop: 2.
  - add/sub/ld/st: 4.
- All enables take effect at the rising edge that ends the cycle in which they are asserted. `ir` is therefore valid from T1 onward.

## Test plan
- Reset mid-add: assert `resetn=0` during T2 of an add → outputs 0 at once. After release, with `run=0`, the block stays in IDLE with all outputs 0.
- mvi: `run=1`, DIN-loaded `ir=16'h2400` (mvi R1) → T1 shows `bus_sel=9`, `r_we=8'b00000010`, `done=1`. IDLE on the next cycle.
- add: `ir=16'h4080` (add R0,R1) → T1 `bus_sel=0`, `a_we`; T2 `bus_sel=1`, `g_we`, `add_sub=0`; T3 `bus_sel=8`, `r_we=8'b00000001`, `done`.
- sub vs add: `ir=16'h6080` gives `add_sub=1` in T2, otherwise the same sequence as add.
- mvnz: `ir=16'hC080` with `g_nz=0` → `done=1`, `r_we=0`. With `g_nz=1` → `r_we=8'b00000001`, `bus_sel=1`.
- st then ld, back-to-back with `run` held high:
  - st `ir=16'hA080`: T1 `addr_we`, `bus_sel=1`; T2 `dout_we`, `bus_sel=0`; T3 `mem_we`, `done`.
  - `run` held high during the st is ignored.
  - ld `ir=16'h8080` then starts on the following IDLE cycle: T1 `addr_we`, `bus_sel=1`; T2 no enables; T3 `bus_sel=9`, `r_we=8'b00000001`, `done`.
